// File: rtl/sweeper_pkg.sv
// ---------------------------------------------------------------------------
// sweeper_pkg
// Shared definitions for the exhaustive vector sweeper:
//   - sweep_state_e : sweep FSM states
//   - DEFAULT_POLY  : default MISR feedback polynomial
//   - DEFAULT_SEED  : default MISR start value
//   - gray_map()    : maps a sweep index to the pattern driven to the DUT
//   - misr_next()   : one MISR step on a signature of up to 32 bits
// ---------------------------------------------------------------------------
package sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

    // Index to pattern: plain binary, or reflected Gray code so that
    // consecutive patterns differ in a single bit.
    function automatic logic [16:0] gray_map(input logic [16:0] idx, input logic gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    // Shift left, fold the outgoing MSB back through the polynomial, then
    // XOR in the new response. Results are masked to 'width' bits so one
    // function serves every signature width up to 32.
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [31:0] poly,
                                              input logic [31:0] data,
                                              input int          width);
        logic [31:0] mask;
        logic [31:0] top;
        logic [31:0] shifted;
        mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        top     = sig >> (width - 1);
        shifted = sig << 1;
        return (shifted ^ (top[0] ? poly : 32'd0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/sweeper_misr.sv
// ---------------------------------------------------------------------------
// sweeper_misr
// Multiple-input signature register that compacts the sampled DUT responses
// of a sweep into a single word.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset, loads SEED
//   load_i  - reload SEED (start of a new sweep); wins over en_i
//   en_i    - fold data_i into the signature this cycle
//   data_i  - zero-extended DUT response
//   sig_o   - current signature
// ---------------------------------------------------------------------------
module sweeper_misr
    import sweeper_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    // Next signature: hold unless the sweep reloads or folds in a response.
    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = WIDTH'(misr_next(32'(sig_q), 32'(POLY), 32'(data_i), WIDTH));
        end
    end

    // Signature register; reset puts it back at the seed.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/exhaustive_vector_sweeper.sv
// ---------------------------------------------------------------------------
// exhaustive_vector_sweeper
// Drives every one of the 2^N_IN input patterns into a DUT, waits SETTLE
// cycles, samples the response and streams (pattern, response) records to a
// logger over valid/ready, while compacting all responses into a MISR.
// Ports:
//   CK         - clock, all state on rising edge
//   reset      - synchronous active-low reset
//   start      - pulse, begins a sweep from IDLE or DONE
//   abort      - pulse, ends any sweep and returns to IDLE (beats start)
//   dut_in     - pattern currently driven to the DUT
//   dut_out    - DUT response
//   rec_valid  - record available
//   rec_ready  - logger accepts record
//   rec_pat    - pattern of the current record
//   rec_resp   - response of the current record
//   signature  - running MISR value
//   busy       - high while settling or emitting
//   done       - high once the whole sweep has been emitted
// ---------------------------------------------------------------------------
module exhaustive_vector_sweeper
    import sweeper_pkg::*;
#(
    parameter int                N_IN   = 4,
    parameter int                N_OUT  = 1,
    parameter int                SETTLE = 1,
    parameter int                GRAY   = 0,
    parameter int                MISR_W = 16,
    parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY),
    parameter logic [MISR_W-1:0] SEED   = MISR_W'(DEFAULT_SEED)
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [N_IN-1:0]   rec_pat,
    output logic [N_OUT-1:0]  rec_resp,
    output logic [MISR_W-1:0] signature,
    output logic              busy,
    output logic              done
);

    // The settle counter only ever holds SETTLE-1 down to 0.
    localparam int               CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    // idx carries one spare bit so the terminal compare cannot alias on wrap.
    localparam logic [N_IN:0]    IDX_LAST   = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0]    IDX_ONE    = (N_IN + 1)'(1);

    sweep_state_e     state_q, state_d;
    logic [N_IN:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  dut_in_q, dut_in_d;
    logic             rec_valid_q, rec_valid_d;
    logic [N_IN-1:0]  rec_pat_q, rec_pat_d;
    logic [N_OUT-1:0] rec_resp_q, rec_resp_d;
    logic [N_IN:0]    idx_inc;
    logic             misr_load;
    logic             misr_en;

    // Sweep sequencing. abort overrides everything except reset; in EMIT
    // all record fields and dut_in simply hold while the logger stalls.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dut_in_d    = dut_in_q;
        rec_valid_d = rec_valid_q;
        rec_pat_d   = rec_pat_q;
        rec_resp_d  = rec_resp_q;
        misr_load   = 1'b0;
        misr_en     = 1'b0;
        idx_inc     = idx_q + IDX_ONE;

        if (abort) begin
            state_d     = ST_IDLE;
            rec_valid_d = 1'b0;
            dut_in_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_d     = '0;
                        // map(0) is zero in both binary and Gray order
                        dut_in_d  = '0;
                        cnt_d     = CNT_RELOAD;
                        misr_load = 1'b1;
                        state_d   = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        rec_pat_d   = dut_in_q;
                        rec_resp_d  = dut_out;
                        rec_valid_d = 1'b1;
                        misr_en     = 1'b1;
                        state_d     = ST_EMIT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_EMIT: begin
                    if (rec_valid_q && rec_ready) begin
                        rec_valid_d = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d    = idx_inc;
                            dut_in_d = N_IN'(gray_map(17'(idx_inc), GRAY != 0));
                            cnt_d    = CNT_RELOAD;
                            state_d  = ST_SETTLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and record registers with synchronous active-low reset.
    always_ff @(posedge CK) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            dut_in_q    <= '0;
            rec_valid_q <= 1'b0;
            rec_pat_q   <= '0;
            rec_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dut_in_q    <= dut_in_d;
            rec_valid_q <= rec_valid_d;
            rec_pat_q   <= rec_pat_d;
            rec_resp_q  <= rec_resp_d;
        end
    end

    // The MISR folds in the response on the same edge the record is latched,
    // so a stalled record never updates the signature twice.
    sweeper_misr #(
        .WIDTH (MISR_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk_i  (CK),
        .rst_ni (reset),
        .load_i (misr_load),
        .en_i   (misr_en),
        .data_i (MISR_W'(dut_out)),
        .sig_o  (signature)
    );

    assign dut_in    = dut_in_q;
    assign rec_valid = rec_valid_q;
    assign rec_pat   = rec_pat_q;
    assign rec_resp  = rec_resp_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_EMIT);
    assign done      = (state_q == ST_DONE);

endmodule
